// File: rtl/updn_cnt_ctrl.sv
// Round-robin sequencer for a shared wrap-around up/down counter; one requester owns it per command.
// Grant costs one edge, then one count step per unpaused edge; pause stalls stepping, requests wait in IDLE.
module updn_cnt_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              dir0,
  input  logic [STEP_W-1:0] steps0,
  input  logic              req1,
  input  logic              dir1,
  input  logic [STEP_W-1:0] steps1,
  input  logic              pause,
  output logic              ack0,
  output logic              ack1,
  output logic              owner,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]        state;
  logic              ptr;
  logic              dir_q;
  logic [STEP_W-1:0] rem;

  logic              gnt_vld;
  logic              gnt_idx;
  logic              sel_dir;
  logic [STEP_W-1:0] sel_steps;

  // ptr=0 favours requester 0 when both requests are pending
  always_comb begin
    gnt_vld   = req0 | req1;
    gnt_idx   = (req0 && req1) ? ptr : req1;
    sel_dir   = gnt_idx ? dir1 : dir0;
    sel_steps = gnt_idx ? steps1 : steps0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      dir_q <= 1'b0;
      rem   <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      owner <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            ack0  <= ~gnt_idx;
            ack1  <= gnt_idx;
            owner <= gnt_idx;
            ptr   <= ~gnt_idx;
            dir_q <= sel_dir;
            rem   <= sel_steps;
            busy  <= (sel_steps != '0);
            state <= (sel_steps != '0) ? RUN : FIN;
          end
        end
        RUN: begin
          if (!pause) begin
            count <= dir_q ? count - WIDTH'(1) : count + WIDTH'(1);
            rem   <= rem - STEP_W'(1);
            if (rem == STEP_W'(1)) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        FIN: begin
          // A zero-step command enters FIN with done low so its done trails its ack by a cycle
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updn_cnt_ctrl.sv
// Directed bench for updn_cnt_ctrl: each scenario task drives vectors and checks hand-computed values.
module tb_updn_cnt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, dir0, req1, dir1, pause;
  logic [3:0] steps0, steps1;
  logic       ack0, ack1, owner, busy, done;
  logic [3:0] count;

  int vecs = 0;
  int errs = 0;

  updn_cnt_ctrl #(.WIDTH(4), .STEP_W(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .dir0(dir0), .steps0(steps0),
    .req1(req1), .dir1(dir1), .steps1(steps1),
    .pause(pause),
    .ack0(ack0), .ack1(ack1), .owner(owner),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request, let the grant edge pass, then drop it (seen ack)
  task automatic issue(input logic side, input logic d, input logic [3:0] n);
    if (side == 1'b0) begin req0 = 1'b1; dir0 = d; steps0 = n; end
    else              begin req1 = 1'b1; dir1 = d; steps1 = n; end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vecs++;
    if ({count, ack0, ack1, owner, busy, done} !== 9'b0) begin
      errs++;
      $display("FAIL reset_state: got count=%0d ack0=%b ack1=%b owner=%b busy=%b done=%b, want all 0",
               count, ack0, ack1, owner, busy, done);
    end
  endtask

  task automatic test_basic_up();
    issue(1'b0, 1'b0, 4'd5);
    vecs++;
    if (ack0 !== 1'b1 || busy !== 1'b1 || count !== 4'd0) begin
      errs++;
      $display("FAIL basic_grant: got ack0=%b busy=%b count=%0d, want 1 1 0", ack0, busy, count);
    end
    dir0 = 1'b1;
    steps0 = 4'd15;
    for (int i = 1; i <= 5; i++) begin
      tick();
      vecs++;
      if (count !== 4'(i) || ack0 !== 1'b0 || done !== (i == 5) || busy !== (i != 5)) begin
        errs++;
        $display("FAIL basic_step%0d: got count=%0d ack0=%b done=%b busy=%b, want count=%0d ack0=0 done=%b busy=%b",
                 i, count, ack0, done, busy, i, (i == 5), (i != 5));
      end
    end
    tick();
    vecs++;
    if (done !== 1'b0 || count !== 4'd5 || owner !== 1'b0) begin
      errs++;
      $display("FAIL basic_end: got done=%b count=%0d owner=%b, want 0 5 0", done, count, owner);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] up_exp[4];
    logic [3:0] dn_exp[3];
    up_exp = '{4'd14, 4'd15, 4'd0, 4'd1};
    dn_exp = '{4'd0, 4'd15, 4'd14};
    issue(1'b0, 1'b0, 4'd8);
    for (int i = 0; i < 8; i++) tick();
    tick();
    vecs++;
    if (count !== 4'd13) begin
      errs++;
      $display("FAIL wrap_setup: got count=%0d, want 13", count);
    end
    issue(1'b1, 1'b0, 4'd4);
    vecs++;
    if (ack1 !== 1'b1 || owner !== 1'b1) begin
      errs++;
      $display("FAIL wrap_up_grant: got ack1=%b owner=%b, want 1 1", ack1, owner);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (count !== up_exp[i] || done !== (i == 3)) begin
        errs++;
        $display("FAIL wrap_up%0d: got count=%0d done=%b, want count=%0d done=%b",
                 i, count, done, up_exp[i], (i == 3));
      end
    end
    tick();
    issue(1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (count !== dn_exp[i] || done !== (i == 2)) begin
        errs++;
        $display("FAIL wrap_dn%0d: got count=%0d done=%b, want count=%0d done=%b",
                 i, count, done, dn_exp[i], (i == 2));
      end
    end
    tick();
  endtask

  task automatic test_pause();
    int cyc;
    apply_reset();
    issue(1'b0, 1'b0, 4'd6);
    cyc = 0;
    tick(); cyc++;
    tick(); cyc++;
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc++;
      vecs++;
      if (count !== 4'd2 || busy !== 1'b1 || done !== 1'b0) begin
        errs++;
        $display("FAIL pause_hold%0d: got count=%0d busy=%b done=%b, want 2 1 0", i, count, busy, done);
      end
    end
    pause = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      tick(); cyc++;
      vecs++;
      if (count !== 4'(i) || done !== (i == 6)) begin
        errs++;
        $display("FAIL pause_step%0d: got count=%0d done=%b, want count=%0d done=%b",
                 i, count, done, i, (i == 6));
      end
    end
    vecs++;
    if (cyc !== 9) begin
      errs++;
      $display("FAIL pause_latency: done after %0d edges, want 9", cyc);
    end
    tick();
  endtask

  task automatic test_zero_steps();
    logic [3:0] c0;
    c0 = count;
    issue(1'b1, 1'b0, 4'd0);
    vecs++;
    if (ack1 !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_grant: got ack1=%b done=%b busy=%b, want 1 0 0", ack1, done, busy);
    end
    tick();
    vecs++;
    if (ack1 !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || count !== c0) begin
      errs++;
      $display("FAIL zero_done: got ack1=%b done=%b busy=%b count=%0d, want 0 1 0 %0d",
               ack1, done, busy, count, c0);
    end
    tick();
    vecs++;
    if (done !== 1'b0 || count !== c0) begin
      errs++;
      $display("FAIL zero_end: got done=%b count=%0d, want 0 %0d", done, count, c0);
    end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    apply_reset();
    issue(1'b0, 1'b0, 4'd8);
    tick(); tick(); tick();
    vecs++;
    if (count !== 4'd3) begin
      errs++;
      $display("FAIL midrun_setup: got count=%0d, want 3", count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vecs++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL midrun_reset: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
    end
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    vecs++;
    if (dones !== 0 || count !== 4'd0) begin
      errs++;
      $display("FAIL midrun_idle: got %0d done pulses count=%0d, want 0 0", dones, count);
    end
  endtask

  task automatic test_back_to_back();
    int  grants;
    int  order[4];
    logic re0, re1;
    grants = 0;
    re0 = 1'b0;
    re1 = 1'b0;
    req0 = 1'b1; dir0 = 1'b0; steps0 = 4'd1;
    req1 = 1'b1; dir1 = 1'b0; steps1 = 4'd1;
    for (int i = 0; i < 40 && grants < 4; i++) begin
      tick();
      if (re0) begin req0 = 1'b1; re0 = 1'b0; end
      if (re1) begin req1 = 1'b1; re1 = 1'b0; end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        vecs++;
        if ((ack0 & ack1) !== 1'b0 || owner !== ack1) begin
          errs++;
          $display("FAIL b2b_owner%0d: got ack0=%b ack1=%b owner=%b, want one ack matching owner",
                   grants, ack0, ack1, owner);
        end
        order[grants] = ack1 ? 1 : 0;
        grants++;
        if (ack0) begin req0 = 1'b0; re0 = 1'b1; end
        if (ack1) begin req1 = 1'b0; re1 = 1'b1; end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    vecs++;
    if (grants !== 4) begin
      errs++;
      $display("FAIL b2b_timeout: got %0d grants in 40 cycles, want 4", grants);
    end else begin
      for (int g = 0; g < 4; g++) begin
        vecs++;
        if (order[g] !== (g % 2)) begin
          errs++;
          $display("FAIL b2b_order%0d: got requester %0d, want %0d", g, order[g], g % 2);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; dir0 = 1'b0; steps0 = 4'd0;
    req1 = 1'b0; dir1 = 1'b0; steps1 = 4'd0;
    pause = 1'b0;
    test_reset();
    test_basic_up();
    test_wrap();
    test_pause();
    test_zero_steps();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
